pu_demultiplexer: RTL and testbench

//   Bus-attached processing unit that is the inverse of the selector PU.
//   - Loads one data word and one select index from the shared data bus.
//   - Emits 2**SEL_WIDTH words back onto the bus, one per out_active cycle:
//     the latched word in slot `sel`, zero in every other slot.
//   - Sits downstream of bus producers and upstream of consumers, including the selector PU.

---
 rtl/pu_demultiplexer.sv | 138 +++++++++++++
 tb/tb_pu_demultiplexer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pu_demultiplexer.sv
// ============================================================================
// Module   : pu_demultiplexer
// Brief    : Latches one word and a select index from the bus, then emits
//            2**SEL_WIDTH slots: the word in slot sel, zero elsewhere.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_demultiplexer #(
    parameter int DATA_WIDTH = 32,
    parameter int ATTR_WIDTH = 4,
    parameter int SEL_WIDTH  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_active,
    input  logic                         sel_active,
    input  logic                         out_active,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic        [ATTR_WIDTH-1:0] attr_in,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic        [ATTR_WIDTH-1:0] attr_out
);

    localparam logic [SEL_WIDTH:0] c_LAST = {1'b0, {SEL_WIDTH{1'b1}}};
    localparam logic [SEL_WIDTH:0] c_ONE  = {{SEL_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GOT_DATA = 3'd1,
        S_GOT_SEL  = 3'd2,
        S_READY    = 3'd3,
        S_EMIT     = 3'd4
    } state_t;

    state_t                         r_state,   w_state_nxt;
    logic signed [DATA_WIDTH-1:0]   r_value,   w_value_nxt;
    logic                           r_val_inv, w_val_inv_nxt;
    logic        [SEL_WIDTH-1:0]    r_sel,     w_sel_nxt;
    logic                           r_sel_ok,  w_sel_ok_nxt;
    logic        [SEL_WIDTH:0]      r_rd_idx,  w_rd_idx_nxt;
    logic                           r_err,     w_err_nxt;

    logic w_can_emit;
    logic w_hit;
    logic w_sel_in_range;

    assign w_can_emit     = (r_state == S_READY) || (r_state == S_EMIT);
    assign w_hit          = (r_rd_idx == {1'b0, r_sel});
    // Arithmetic shift leaves zero only for 0 <= data_in < 2**SEL_WIDTH.
    assign w_sel_in_range = ((data_in >>> SEL_WIDTH) == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_value_nxt   = r_value;
        w_val_inv_nxt = r_val_inv;
        w_sel_nxt     = r_sel;
        w_sel_ok_nxt  = r_sel_ok;
        w_rd_idx_nxt  = r_rd_idx;
        w_err_nxt     = r_err;
        data_out      = '0;
        attr_out      = '0;

        if (out_active) begin
            if (w_can_emit) begin
                data_out    = (w_hit && r_sel_ok) ? r_value : '0;
                attr_out[0] = (w_hit && r_val_inv) || !r_sel_ok;
                attr_out[1] = r_err;
                if (r_rd_idx == c_LAST) begin
                    w_state_nxt  = S_IDLE;
                    w_rd_idx_nxt = '0;
                    w_err_nxt    = 1'b0;
                end else begin
                    w_state_nxt  = S_EMIT;
                    w_rd_idx_nxt = r_rd_idx + c_ONE;
                end
            end else begin
                attr_out[1:0] = 2'b11;
                w_err_nxt     = 1'b1;
            end
            // A load strobe colliding with a read is dropped and flagged.
            if (data_active || sel_active) begin
                w_err_nxt = 1'b1;
            end
        end else if (data_active && sel_active) begin
            w_err_nxt = 1'b1;
        end else if (data_active) begin
            w_value_nxt   = data_in;
            w_val_inv_nxt = attr_in[0];
            case (r_state)
                S_IDLE:    w_state_nxt = S_GOT_DATA;
                S_GOT_SEL: w_state_nxt = S_READY;
                S_EMIT: begin
                    w_state_nxt  = S_GOT_DATA;
                    w_rd_idx_nxt = '0;
                    w_err_nxt    = 1'b0;
                end
                default:   w_state_nxt = r_state;
            endcase
        end else if (sel_active) begin
            w_sel_nxt    = data_in[SEL_WIDTH-1:0];
            w_sel_ok_nxt = w_sel_in_range;
            case (r_state)
                S_IDLE:     w_state_nxt = S_GOT_SEL;
                S_GOT_DATA: w_state_nxt = S_READY;
                S_EMIT: begin
                    w_state_nxt  = S_GOT_SEL;
                    w_rd_idx_nxt = '0;
                    w_err_nxt    = 1'b0;
                end
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_value   <= '0;
            r_val_inv <= 1'b0;
            r_sel     <= '0;
            r_sel_ok  <= 1'b0;
            r_rd_idx  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_value   <= w_value_nxt;
            r_val_inv <= w_val_inv_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_ok  <= w_sel_ok_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_err     <= w_err_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pu_demultiplexer.sv
// ============================================================================
// Module   : tb_pu_demultiplexer
// Brief    : Drives a 2-slot and a 4-slot demultiplexer in lockstep against
//            a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pu_demultiplexer;

    localparam int c_DW = 32;
    localparam int c_AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   data_active;
    logic                   sel_active;
    logic                   out_active;
    logic signed [c_DW-1:0] data_in;
    logic        [c_AW-1:0] attr_in;
    logic signed [c_DW-1:0] data_out1, data_out2;
    logic        [c_AW-1:0] attr_out1, attr_out2;

    pu_demultiplexer #(.DATA_WIDTH(c_DW), .ATTR_WIDTH(c_AW), .SEL_WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_active(data_active), .sel_active(sel_active),
        .out_active(out_active), .data_in(data_in), .attr_in(attr_in),
        .data_out(data_out1), .attr_out(attr_out1)
    );

    pu_demultiplexer #(.DATA_WIDTH(c_DW), .ATTR_WIDTH(c_AW), .SEL_WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .data_active(data_active), .sel_active(sel_active),
        .out_active(out_active), .data_in(data_in), .attr_in(attr_in),
        .data_out(data_out2), .attr_out(attr_out2)
    );

    int checks = 0;
    int errors = 0;

    // Model: which operands are held, how many slots already read, error flag.
    int m_n[2] = '{2, 4};
    bit m_hd[2], m_hs[2], m_inv[2], m_err[2];
    int m_pos[2], m_val[2], m_sel[2];

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint exp_data(input int k, input bit o);
        int s;
        bit ok;
        if (!o || !(m_hd[k] && m_hs[k])) return 0;
        ok = (m_sel[k] >= 0) && (m_sel[k] < m_n[k]);
        s  = m_sel[k] & (m_n[k] - 1);
        return (ok && m_pos[k] == s) ? longint'(m_val[k]) : 0;
    endfunction

    function automatic longint exp_attr(input int k, input bit o);
        int s;
        bit ok;
        if (!o) return 0;
        if (!(m_hd[k] && m_hs[k])) return 3;
        ok = (m_sel[k] >= 0) && (m_sel[k] < m_n[k]);
        s  = m_sel[k] & (m_n[k] - 1);
        return ((((m_pos[k] == s) && m_inv[k]) || !ok) ? 1 : 0) + (m_err[k] ? 2 : 0);
    endfunction

    task automatic model_step(input bit r, input bit d, input bit s, input bit o,
                              input int din, input int ain);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_hd[k] = 0; m_hs[k] = 0; m_inv[k] = 0; m_err[k] = 0;
                m_pos[k] = 0; m_val[k] = 0; m_sel[k] = 0;
            end else if (o) begin
                if (m_hd[k] && m_hs[k]) begin
                    m_pos[k]++;
                    if (m_pos[k] == m_n[k]) begin
                        m_hd[k] = 0; m_hs[k] = 0; m_pos[k] = 0; m_err[k] = 0;
                    end
                end else begin
                    m_err[k] = 1;
                end
                if (d || s) m_err[k] = 1;
            end else if (d && s) begin
                m_err[k] = 1;
            end else if (d) begin
                if (m_pos[k] > 0) begin
                    m_hs[k] = 0; m_pos[k] = 0; m_err[k] = 0;
                end
                m_hd[k] = 1; m_val[k] = din; m_inv[k] = ain[0];
            end else if (s) begin
                if (m_pos[k] > 0) begin
                    m_hd[k] = 0; m_pos[k] = 0; m_err[k] = 0;
                end
                m_hs[k] = 1; m_sel[k] = din;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit d, input bit s, input bit o,
                       input int din, input int ain);
        @(negedge clk);
        rst = r; data_active = d; sel_active = s; out_active = o;
        data_in = din; attr_in = c_AW'(ain);
        #1;
        check("n2_data", longint'(data_out1), exp_data(0, o));
        check("n2_attr", longint'(attr_out1), exp_attr(0, o));
        check("n4_data", longint'(data_out2), exp_data(1, o));
        check("n4_attr", longint'(attr_out2), exp_attr(1, o));
        @(posedge clk);
        model_step(r, d, s, o, din, ain);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; data_active = 1'b0; sel_active = 1'b0; out_active = 1'b0;
        data_in = '0; attr_in = '0;

        do_reset();
        cyc(0, 0, 0, 0, 0, 0);

        // Data then select, full read.
        cyc(0, 1, 0, 0, 42, 0);
        cyc(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        // Select before data.
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, -7, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        // Out-of-range select.
        cyc(0, 1, 0, 0, 5, 0);
        cyc(0, 0, 1, 0, 4, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        // Invalid payload flag follows the selected slot.
        cyc(0, 1, 0, 0, 9, 1);
        cyc(0, 0, 1, 0, 2, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        // Partial read aborted by a new load.
        cyc(0, 1, 0, 0, 3, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 8, 0);
        cyc(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        // Read in IDLE, colliding strobes, reset mid-emit.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 6, 0);
        cyc(0, 1, 0, 0, 11, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        do_reset();

        for (int it = 0; it < 1500; it++) begin
            int op, din, ain, burst;
            op  = $urandom_range(0, 19);
            din = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 8)) - 2;
            ain = int'($urandom_range(0, 15));
            if (op < 5)       cyc(0, 1, 0, 0, din, ain);
            else if (op < 10) cyc(0, 0, 1, 0, din, ain);
            else if (op < 15) begin
                burst = int'($urandom_range(1, 5));
                for (int b = 0; b < burst; b++) cyc(0, 0, 0, 1, 0, 0);
            end
            else if (op == 15) cyc(0, 1, 1, 0, din, ain);
            else if (op == 16) cyc(0, $urandom_range(0, 1) == 1, 1'b1, 1'b1, din, ain);
            else if (op == 17) cyc(1, 0, 0, 0, 0, 0);
            else               cyc(0, 0, 0, 0, din, ain);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
